instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/sa_isa_pkg.sv | 51 +++++
 rtl/instr_word_pack.sv | 19 +
 rtl/instr_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/sa_isa_pkg.sv
// Shared ISA definitions for the systolic-array instruction path: opcodes,
// instruction field layout, host command encodings and buffer depths.
package sa_isa_pkg;

   localparam int INSTR_W  = 64;
   localparam int OPC_LSB  = 0;
   localparam int OPC_W    = 5;
   localparam int ADDR_LSB = 5;
   localparam int ADDR_W   = 16;
   localparam int DATA_LSB = 21;
   localparam int DATA_W   = 32;

   localparam int LOAD_DEPTH  = 128;
   localparam int DRAIN_DEPTH = 16;
   localparam int LOAD_AW     = $clog2(LOAD_DEPTH);
   localparam int DRAIN_AW    = $clog2(DRAIN_DEPTH);

   localparam int CMD_W = 3;
   localparam int LEN_W = 7;

   localparam logic [OPC_W-1:0] OP_NOP       = 5'b00000;
   localparam logic [OPC_W-1:0] OP_COMPUTE   = 5'b00001;
   localparam logic [OPC_W-1:0] OP_COMPUTE_I = 5'b00010;
   localparam logic [OPC_W-1:0] OP_ACC_TO_OB = 5'b00011;
   localparam logic [OPC_W-1:0] OP_INP_WR    = 5'b00100;
   localparam logic [OPC_W-1:0] OP_WT_WR     = 5'b00101;
   localparam logic [OPC_W-1:0] OP_OB_SEND   = 5'b00110;
   localparam logic [OPC_W-1:0] OP_ACC_RST   = 5'b00111;

   localparam logic [CMD_W-1:0] CMD_LOAD_INP  = 3'd0;
   localparam logic [CMD_W-1:0] CMD_LOAD_WT   = 3'd1;
   localparam logic [CMD_W-1:0] CMD_COMPUTE   = 3'd2;
   localparam logic [CMD_W-1:0] CMD_COMPUTE_I = 3'd3;
   localparam logic [CMD_W-1:0] CMD_DRAIN     = 3'd4;
   localparam logic [CMD_W-1:0] CMD_RESET_ACC = 3'd5;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      COMP,
      DRAIN_A,
      DRAIN_S,
      RSTA
   } seq_state_t;

   // A drain never walks past the end of the accumulator buffer.
   function automatic logic [LEN_W-1:0] drainLen(input logic [LEN_W-1:0] len);
      return (len > LEN_W'(DRAIN_DEPTH)) ? LEN_W'(DRAIN_DEPTH) : len;
   endfunction

endpackage

// File: rtl/instr_word_pack.sv
// Assembles the 64-bit decoder instruction from opcode, address and data;
// unused upper bits are always zero.
module instr_word_pack
   import sa_isa_pkg::*;
(
   input  logic [OPC_W-1:0]   i_opcode,
   input  logic [ADDR_W-1:0]  i_addr,
   input  logic [DATA_W-1:0]  i_data,
   output logic [INSTR_W-1:0] o_instr
);

   always_comb begin
      o_instr = '0;
      o_instr[OPC_LSB +: OPC_W]   = i_opcode;
      o_instr[ADDR_LSB +: ADDR_W] = i_addr;
      o_instr[DATA_LSB +: DATA_W] = i_data;
   end

endmodule

// File: rtl/instr_sequencer.sv
// Expands host commands into a stream of one decoder instruction per cycle.
// The fields are registered together with the state, so the word shown is always the current step.
module instr_sequencer
   import sa_isa_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [CMD_W-1:0]   cmd_op,
   input  logic [LEN_W-1:0]   cmd_base,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic               din_valid,
   input  logic [DATA_W-1:0]  din_data,
   output logic               din_ready,
   output logic [INSTR_W-1:0] instruction,
   output logic               busy,
   output logic               done
);

   localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

   seq_state_t          r_state;
   logic [CMD_W-1:0]    r_op;
   logic [LEN_W-1:0]    r_base;
   logic [LEN_W-1:0]    r_len;
   logic [LEN_W-1:0]    r_cnt;
   logic [OPC_W-1:0]    r_opcode;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_data;
   logic                r_done;

   logic                w_isLoadCmd;
   logic [OPC_W-1:0]    w_cmdLoadOpc;
   logic [OPC_W-1:0]    w_loadOpc;
   logic [LOAD_AW-1:0]  w_loadAddr;
   logic [DRAIN_AW-1:0] w_drainNext;
   logic                w_lastStep;
   logic                w_loadAccept;

   assign w_isLoadCmd  = (cmd_op == CMD_LOAD_INP) || (cmd_op == CMD_LOAD_WT);
   assign w_cmdLoadOpc = (cmd_op == CMD_LOAD_WT) ? OP_WT_WR : OP_INP_WR;
   assign w_loadOpc    = (r_op == CMD_LOAD_WT) ? OP_WT_WR : OP_INP_WR;
   assign w_loadAddr   = r_base + r_cnt;
   assign w_drainNext  = r_addr[DRAIN_AW-1:0] + DRAIN_AW'(1);
   assign w_lastStep   = (r_cnt + ONE) == r_len;

   // The first load word is taken on the accepting edge so it appears the very next cycle.
   assign w_loadAccept = cmd_valid && cmd_ready && w_isLoadCmd && (cmd_len != '0);
   assign din_ready    = !rst && din_valid &&
                         (((r_state == LOAD) && !r_done) || w_loadAccept);

   assign cmd_ready = (r_state == IDLE);
   assign busy      = (r_state != IDLE);
   assign done      = r_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_op     <= '0;
         r_base   <= '0;
         r_len    <= '0;
         r_cnt    <= '0;
         r_opcode <= OP_NOP;
         r_addr   <= '0;
         r_data   <= '0;
         r_done   <= 1'b0;
      end else if (r_done) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_opcode <= OP_NOP;
         r_addr   <= '0;
         r_data   <= '0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (cmd_valid) begin
                  r_op   <= cmd_op;
                  r_base <= cmd_base;
                  r_len  <= cmd_len;
                  r_cnt  <= '0;
                  if (cmd_op == CMD_RESET_ACC) begin
                     r_state  <= RSTA;
                     r_opcode <= OP_ACC_RST;
                     r_done   <= 1'b1;
                  end else if ((cmd_len == '0) || (cmd_op > CMD_RESET_ACC)) begin
                     // Empty or illegal commands cost one NOP cycle carrying done.
                     r_state <= COMP;
                     r_done  <= 1'b1;
                  end else if (w_isLoadCmd) begin
                     r_state <= LOAD;
                     if (din_valid) begin
                        r_opcode <= w_cmdLoadOpc;
                        r_addr   <= ADDR_W'(cmd_base);
                        r_data   <= din_data;
                        r_cnt    <= ONE;
                        r_done   <= (cmd_len == ONE);
                     end
                  end else if (cmd_op == CMD_DRAIN) begin
                     r_state  <= DRAIN_A;
                     r_opcode <= OP_ACC_TO_OB;
                     r_addr   <= ADDR_W'(cmd_base[DRAIN_AW-1:0]);
                  end else begin
                     r_state  <= COMP;
                     r_opcode <= (cmd_op == CMD_COMPUTE_I) ? OP_COMPUTE_I : OP_COMPUTE;
                     r_cnt    <= ONE;
                     r_done   <= (cmd_len == ONE);
                  end
               end
            end
            LOAD: begin
               if (din_valid) begin
                  r_opcode <= w_loadOpc;
                  r_addr   <= ADDR_W'(w_loadAddr);
                  r_data   <= din_data;
                  r_cnt    <= r_cnt + ONE;
                  r_done   <= w_lastStep;
               end else begin
                  r_opcode <= OP_NOP;
                  r_addr   <= '0;
                  r_data   <= '0;
               end
            end
            COMP: begin
               r_cnt  <= r_cnt + ONE;
               r_done <= w_lastStep;
            end
            DRAIN_A: begin
               r_state  <= DRAIN_S;
               r_opcode <= OP_OB_SEND;
               r_done   <= (r_cnt + ONE) == drainLen(r_len);
            end
            DRAIN_S: begin
               r_state  <= DRAIN_A;
               r_opcode <= OP_ACC_TO_OB;
               r_addr   <= ADDR_W'(w_drainNext);
               r_cnt    <= r_cnt + ONE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   instr_word_pack uPack (
      .i_opcode (r_opcode),
      .i_addr   (r_addr),
      .i_data   (r_data),
      .o_instr  (instruction)
   );

endmodule
